// File: rtl/drive_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drive_arb_pkg
//  Purpose  : Command, source, mode and FSM-state encodings shared by the
//             drive command arbiter and its helpers.
//  Revision : 1.0
// ============================================================================
package drive_arb_pkg;

    typedef enum logic [2:0] {
        CMD_STOP  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_RIGHT = 3'd3,
        CMD_REV   = 3'd4
    } cmd_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MIC  = 2'd1,
        SRC_IR   = 2'd2,
        SRC_VIS  = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_TRACK  = 2'd2,
        MODE_ESTOP  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] c_cmd_max = 3'd4;

    // Reserved IR codes are treated as STOP so a corrupted remote cannot drive.
    function automatic cmd_t ir_to_cmd(input logic [2:0] code);
        if (code <= c_cmd_max) begin
            return cmd_t'(code);
        end
        return CMD_STOP;
    endfunction

    function automatic cmd_t vis_to_cmd(input logic [1:0] dir);
        case (dir)
            2'b00:   return CMD_FWD;
            2'b01:   return CMD_LEFT;
            2'b10:   return CMD_RIGHT;
            default: return CMD_STOP;
        endcase
    endfunction

    function automatic mode_t src_to_mode(input src_t src);
        case (src)
            SRC_MIC: return MODE_ESTOP;
            SRC_IR:  return MODE_MANUAL;
            SRC_VIS: return MODE_TRACK;
            default: return MODE_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : arb_timer
//  Purpose  : Loadable down-counter that saturates at zero, with zero flag.
//  Revision : 1.0
// ============================================================================
module arb_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/drive_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : drive_cmd_arbiter
//  Purpose  : Arbitrates MIC / IR / vision drive requests into a rate-limited
//             valid/ready command stream. Define DRIVE_ARB_MIC_STOP_EN to
//             enable the microphone emergency-stop path.
//  Revision : 1.0
// ============================================================================
module drive_cmd_arbiter
    import drive_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 5000000,
    parameter int unsigned TIMEOUT_CYCLES = 25000000,
    parameter int unsigned MIC_THRESH     = 12
) (
    input  logic       clk_50,
    input  logic       resend,
    input  logic       ir_valid,
    input  logic [2:0] ir_cmd,
    input  logic [1:0] vis_dir,
    input  logic       vis_detected,
    input  logic [3:0] mic_level,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_data,
    output logic [1:0] cmd_src,
    output logic [1:0] mode
);

    localparam int unsigned c_hold_w = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned c_win_w  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES);
    localparam logic [c_win_w-1:0]  c_win_load  = c_win_w'(TIMEOUT_CYCLES);

    logic   w_mic_stop;
    logic   w_win_open;
    logic   w_win_zero;
    logic   w_hold_zero;
    logic   w_cand_new;
    logic   w_load_pend;
    logic   w_transfer;
    cmd_t   w_cand_data;
    src_t   w_cand_src;
    state_t r_state;
    state_t w_state_next;
    cmd_t   r_ir_cmd;
    cmd_t   r_pend_data;
    src_t   r_pend_src;
    cmd_t   r_last_data;
    src_t   r_last_src;

`ifdef DRIVE_ARB_MIC_STOP_EN
    assign w_mic_stop = (32'(mic_level) >= MIC_THRESH);
`else
    logic w_unused_mic;
    assign w_unused_mic = ^{mic_level, MIC_THRESH};
    assign w_mic_stop   = 1'b0;
`endif

    // An IR pulse during an emergency stop closes the window instead of opening it.
    arb_timer #(
        .WIDTH (c_win_w)
    ) u_win_timer (
        .clk        (clk_50),
        .rst        (resend),
        .i_load     (ir_valid),
        .i_load_val (w_mic_stop ? '0 : c_win_load),
        .i_dec      (1'b1),
        .o_zero     (w_win_zero)
    );

    arb_timer #(
        .WIDTH (c_hold_w)
    ) u_hold_timer (
        .clk        (clk_50),
        .rst        (resend),
        .i_load     (w_transfer),
        .i_load_val (c_hold_load),
        .i_dec      (r_state == S_HOLD),
        .o_zero     (w_hold_zero)
    );

    assign w_win_open = !w_win_zero;

    always_ff @(posedge clk_50) begin
        if (resend) begin
            r_ir_cmd <= CMD_STOP;
        end else if (ir_valid && !w_mic_stop) begin
            r_ir_cmd <= ir_to_cmd(ir_cmd);
        end
    end

    always_comb begin
        w_cand_data = CMD_STOP;
        w_cand_src  = SRC_NONE;
        if (w_mic_stop) begin
            w_cand_src = SRC_MIC;
        end else if (w_win_open) begin
            w_cand_data = r_ir_cmd;
            w_cand_src  = SRC_IR;
        end else if (vis_detected) begin
            w_cand_data = vis_to_cmd(vis_dir);
            w_cand_src  = SRC_VIS;
        end
    end

    assign w_cand_new = (w_cand_data != r_last_data) || (w_cand_src != r_last_src);

    always_ff @(posedge clk_50) begin
        if (resend) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_pend  = 1'b0;
        w_transfer   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cand_new) begin
                    w_state_next = S_SEND;
                    w_load_pend  = 1'b1;
                end
            end
            S_SEND: begin
                if (cmd_ready) begin
                    w_state_next = S_HOLD;
                    w_transfer   = 1'b1;
                end
            end
            S_HOLD: begin
                // Only an emergency stop may cut the rate-limit hold short.
                if (w_mic_stop && w_cand_new) begin
                    w_state_next = S_SEND;
                    w_load_pend  = 1'b1;
                end else if (w_hold_zero) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (resend) begin
            r_pend_data <= CMD_STOP;
            r_pend_src  <= SRC_NONE;
            r_last_data <= CMD_STOP;
            r_last_src  <= SRC_NONE;
        end else begin
            if (w_load_pend) begin
                r_pend_data <= w_cand_data;
                r_pend_src  <= w_cand_src;
            end
            if (w_transfer) begin
                r_last_data <= r_pend_data;
                r_last_src  <= r_pend_src;
            end
        end
    end

    assign cmd_valid = (r_state == S_SEND);
    assign cmd_data  = r_pend_data;
    assign cmd_src   = r_pend_src;
    assign mode      = resend ? MODE_IDLE : src_to_mode(w_cand_src);

endmodule
`default_nettype wire
